// File: rtl/systolic_output_deskew.sv
// ============================================================================
// systolic_output_deskew: realigns skewed systolic-array column streams into
// whole result rows and buffers them in a row FIFO. Optional: DESKEW_STALL_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module systolic_output_deskew #(
  parameter int N          = 10,
  parameter int DW         = 16,
  parameter int ROWS       = 19,
  parameter int FIFO_DEPTH = 4,
  localparam int RW = $clog2(ROWS),
  localparam int BW = $clog2(ROWS + N),
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [N*DW-1:0] psum_in_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [N*DW-1:0] out_data_o,
  output logic [RW-1:0]   out_row_o,
  output logic            done_o
`ifdef DESKEW_STALL_CNT_EN
  ,
  output logic [15:0]     stall_cnt_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [BW-1:0]      beat_q;
  logic [N*DW-1:0]    w_row;
  logic [RW-1:0]      w_row_idx;
  logic               w_clear, w_accept, w_last, w_push, w_pop;

  logic [RW+N*DW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_q, rd_q;
  logic [AW:0]        cnt_q, cnt_d;
  logic               full_q;

  assign w_clear    = (state_q == S_IDLE) && start_i;
  assign in_ready_o = (state_q == S_COLLECT) && !full_q;
  assign w_accept   = in_valid_i && in_ready_o;
  assign w_last     = (beat_q == BW'(ROWS + N - 2));
  assign w_push     = w_accept && (beat_q >= BW'(N - 1));
  assign w_pop      = out_valid_o && out_ready_i;
  assign w_row_idx  = RW'(beat_q - BW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           beat_q <= '0;
    else if (w_clear)  beat_q <= '0;
    else if (w_accept) beat_q <= beat_q + BW'(1);
  end

  // Column j is delayed N-1-j accepted beats so every column lines up with column N-1.
  for (genvar j = 0; j < N - 1; j++) begin : g_col
    localparam int D = N - 1 - j;
    logic [DW-1:0] sr_q [D];

    always_ff @(posedge clk or posedge rst) begin
      if (rst || w_clear) begin
        for (int k = 0; k < D; k++) sr_q[k] <= '0;
      end else if (w_accept) begin
        sr_q[0] <= psum_in_i[j*DW +: DW];
        for (int k = 1; k < D; k++) sr_q[k] <= sr_q[k-1];
      end
    end

    assign w_row[j*DW +: DW] = sr_q[D-1];
  end

  assign w_row[(N-1)*DW +: DW] = psum_in_i[(N-1)*DW +: DW];

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_q] <= {w_row_idx, w_row};
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({w_push, w_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // full is registered: a pop in the same cycle does not open space for a push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      if (w_push) wr_q <= wr_q + AW'(1);
      if (w_pop)  rd_q <= rd_q + AW'(1);
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == (AW+1)'(FIFO_DEPTH));
    end
  end

  assign out_valid_o = (cnt_q != '0);
  assign out_data_o  = out_valid_o ? mem_q[rd_q][N*DW-1:0]    : '0;
  assign out_row_o   = out_valid_o ? mem_q[rd_q][RW+N*DW-1:N*DW] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_i)             state_d = S_COLLECT;
      S_COLLECT: if (w_accept && w_last)  state_d = S_DRAIN;
      S_DRAIN:   if (cnt_q == '0)         state_d = S_DONE;
      S_DONE:                             state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
  end

  assign done_o = (state_q == S_DONE);

`ifdef DESKEW_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          stall_cnt_o <= '0;
    else if (w_clear) stall_cnt_o <= '0;
    else if ((state_q == S_COLLECT) && in_valid_i && !in_ready_o && (stall_cnt_o != 16'hFFFF))
      stall_cnt_o <= stall_cnt_o + 16'd1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_systolic_output_deskew.sv
// Bench for systolic_output_deskew: rows are defined as a result matrix, skewed
// into beats by the bench, and the popped rows are compared with the matrix.
`default_nettype none

module tb_systolic_output_deskew;
  localparam int N     = 10;
  localparam int DW    = 16;
  localparam int ROWS  = 19;
  localparam int DEPTH = 4;
  localparam int NB    = ROWS + N - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start_i = 1'b0;
  logic            in_valid_i = 1'b0;
  logic            in_ready_o;
  logic [N*DW-1:0] psum_in_i = '0;
  logic            out_valid_o;
  logic            out_ready_i = 1'b0;
  logic [N*DW-1:0] out_data_o;
  logic [4:0]      out_row_o;
  logic            done_o;
`ifdef DESKEW_STALL_CNT_EN
  logic [15:0]     stall_cnt_o;
`endif

  systolic_output_deskew #(.N(N), .DW(DW), .ROWS(ROWS), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .psum_in_i   (psum_in_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_row_o   (out_row_o),
    .done_o      (done_o)
`ifdef DESKEW_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] res [ROWS][N];

  task automatic check(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [N*DW-1:0] rand_word();
    logic [N*DW-1:0] w;
    for (int k = 0; k < N; k++) w[k*DW +: DW] = DW'($urandom);
    return w;
  endfunction

  // Column j on beat b carries result row b-j; outside the matrix it is 0 or junk.
  function automatic logic [N*DW-1:0] beat_word(input int b, input bit junk);
    logic [N*DW-1:0] w;
    for (int j = 0; j < N; j++) begin
      if (b - j >= 0 && b - j < ROWS) w[j*DW +: DW] = res[b-j][j];
      else                            w[j*DW +: DW] = junk ? DW'($urandom) : '0;
    end
    return w;
  endfunction

  function automatic logic [N*DW-1:0] row_word(input int r);
    logic [N*DW-1:0] w;
    for (int j = 0; j < N; j++) w[j*DW +: DW] = res[r][j];
    return w;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
      check("idle_in_ready", in_ready_o, 1'b0);
      check("idle_done", done_o, 1'b0);
    end
  endtask

  // mode: 0 pattern, 1 pattern with column 3 = -1, 2 random data
  // gap: 0 none, 1 toggle, 2 random; phase: 0 start, 1 collect, 2 drain, 3 done, 4 finished
  task automatic run_job(input int mode, input int hold, input int gap, input bit rrand,
                         input bit spur, input int abort_at);
    int b, pops, occ, phase, stall_m;
    bit vin, rdy, er, acc, push, pop;
    for (int r = 0; r < ROWS; r++)
      for (int j = 0; j < N; j++)
        res[r][j] = (mode == 2) ? DW'($urandom) : (mode == 1 && j == 3) ? 16'hFFFF : DW'(r*16 + j);
    b = 0; pops = 0; occ = 0; phase = 0; stall_m = 0;
    for (int cyc = 0; cyc < 800 && phase != 4; cyc++) begin
      @(negedge clk);
      start_i = (cyc == 0) || (spur && (phase == 1 || phase == 2) && (cyc % 3 == 0));
      if (phase == 1 && b < NB)
        vin = (gap == 0) ? 1'b1 : (gap == 1) ? (cyc % 2 == 1) : 1'($urandom % 2);
      else
        vin = spur && phase != 0;
      in_valid_i  = vin;
      psum_in_i   = (vin && phase == 1) ? beat_word(b, mode == 2) : rand_word();
      rdy         = (cyc < hold) ? 1'b0 : (rrand ? 1'($urandom % 2) : 1'b1);
      out_ready_i = rdy;

      er = (phase == 1) && (occ < DEPTH);
      check("in_ready", in_ready_o, er);
      check("out_valid", out_valid_o, occ > 0);
      check("done", done_o, phase == 3);
      pop = (occ > 0) && rdy;
      if (pop) begin
        check("out_data", out_data_o, row_word(pops));
        check("out_row", out_row_o, pops);
        pops++;
      end
      acc  = vin && er;
      if (phase == 1 && vin && !er) stall_m++;
      push = acc && (b >= N - 1);
      if (acc) b++;
      case (phase)
        0: phase = 1;
        1: if (acc && b == NB) phase = 2;
        2: if (occ == 0) phase = 3;
        3: phase = 4;
        default: ;
      endcase
      occ = occ + int'(push) - int'(pop);

      if (abort_at >= 0 && b >= abort_at && phase == 1) begin
        check("abort_fifo_rows", occ, 3);
        @(negedge clk);
        rst = 1'b1; start_i = 1'b0; in_valid_i = 1'b0;
        #1;
        check("rst_out_valid", out_valid_o, 1'b0);
        check("rst_in_ready", in_ready_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_out_data", out_data_o, '0);
        check("rst_out_row", out_row_o, '0);
`ifdef DESKEW_STALL_CNT_EN
        check("rst_stall_cnt", stall_cnt_o, '0);
`endif
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check("post_rst_done", done_o, 1'b0);
          check("post_rst_out_valid", out_valid_o, 1'b0);
        end
        return;
      end
    end
    check("job_completed", phase == 4, 1'b1);
    check("rows_popped", pops, ROWS);
`ifdef DESKEW_STALL_CNT_EN
    check("stall_cnt", stall_cnt_o, stall_m);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_in_ready", in_ready_o, 1'b0);
    check("reset_out_valid", out_valid_o, 1'b0);
    check("reset_done", done_o, 1'b0);
    check("reset_out_data", out_data_o, '0);
    check("reset_out_row", out_row_o, '0);
`ifdef DESKEW_STALL_CNT_EN
    check("reset_stall_cnt", stall_cnt_o, '0);
`endif
    rst = 1'b0;
    idle(2);

    run_job(0, 0, 0, 1'b0, 1'b0, -1);      // aligned stream
    idle(2);
    run_job(0, 20, 0, 1'b0, 1'b0, -1);     // backpressure
    idle(2);
    run_job(0, 0, 1, 1'b0, 1'b0, -1);      // gapped input
    idle(2);
    run_job(1, 0, 0, 1'b0, 1'b0, -1);      // negative column
    idle(2);
    run_job(0, 1000, 0, 1'b0, 1'b0, 12);   // reset mid-job
    run_job(0, 0, 0, 1'b0, 1'b0, -1);
    idle(2);
    run_job(0, 0, 0, 1'b0, 1'b1, -1);      // spurious start / in_valid
    idle(2);
    for (int i = 0; i < 4; i++) begin
      run_job(2, int'($urandom_range(0, 30)), 2, 1'b1, 1'b0, -1);
      idle(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
